imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the single-cycle core fetches from. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses. It holds the core in reset until the image is complete. It sits between an external byte source (UART/debug bridge) and the write port of the instruction memory.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port for imem_loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface imem_loader_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: word count, then little-endian words written to consecutive addresses.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte checked before DONE.
module imem_loader #(
    parameter int INST_MEMORY_ADDR_BUS_WIDTH = 16,
    parameter int INST_MEMORY_DATA_BUS_WIDTH = 32,
    parameter int BASE_ADDR                  = 0
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);
    localparam int AW = INST_MEMORY_ADDR_BUS_WIDTH;
    localparam int DW = INST_MEMORY_DATA_BUS_WIDTH;
    // Largest word count that fits between BASE_ADDR and the top of the address space.
    localparam longint unsigned CAP_WORDS = ((64'd1 << AW) - 64'(BASE_ADDR)) / 64'd4;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHECK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t        state_q, state_d;
    logic [15:0]   len_q;
    logic [15:0]   k_q;
    logic [1:0]    b_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          byte_ready;
    logic          xfer;
    logic [15:0]   len_full;
    logic [15:0]   k_inc;
    logic          over_cap;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    assign xfer     = bus.byte_valid && byte_ready;
    assign len_full = {bus.byte_in, len_q[7:0]};
    assign k_inc    = k_q + 16'd1;
    assign over_cap = 64'(len_full) > CAP_WORDS;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
        if (rst) state_q <= S_LEN_LO;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d    = state_q;
        byte_ready = 1'b0;
        unique case (state_q)
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (len_full == 16'd0) state_d = S_END;
                    else if (over_cap)     state_d = S_ERROR;
                    else                   state_d = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (bus.byte_valid && b_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: state_d = (k_inc == len_q) ? S_END : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // Datapath: length capture, lane assembly and write address/word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            k_q     <= '0;
            b_q     <= '0;
            addr_q  <= AW'(BASE_ADDR);
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            if (xfer && state_q == S_LEN_LO) len_q[7:0] <= bus.byte_in;
            if (xfer && state_q == S_LEN_HI) begin
                len_q[15:8] <= bus.byte_in;
                k_q         <= '0;
                b_q         <= '0;
            end
            if (xfer && state_q == S_DATA) begin
                wdata_q[{b_q, 3'b000} +: 8] <= bus.byte_in;
                b_q                         <= b_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q                      <= csum_q ^ bus.byte_in;
`endif
            end
            if (state_q == S_WRITE) begin
                k_q    <= k_inc;
                addr_q <= addr_q + AW'(4);
            end
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign cpu_hold       = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: dut_a (AW=16, BASE_ADDR=0x100) and dut_b (AW=6, BASE_ADDR=0)
// share one byte stream; the unselected instance is held in reset.
module tb_imem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, sel_b;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       hold_a, done_a, err_a, hold_b, done_b, err_b;

    imem_loader_if #(.AW(16), .DW(32)) if_a ();
    imem_loader_if #(.AW(6),  .DW(32)) if_b ();

    assign if_a.byte_in    = byte_in;
    assign if_a.byte_valid = byte_valid;
    assign if_b.byte_in    = byte_in;
    assign if_b.byte_valid = byte_valid;

    imem_loader #(.INST_MEMORY_ADDR_BUS_WIDTH(16), .INST_MEMORY_DATA_BUS_WIDTH(32),
                  .BASE_ADDR(32'h100)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave),
        .cpu_hold(hold_a), .done(done_a), .error(err_a));

    imem_loader #(.INST_MEMORY_ADDR_BUS_WIDTH(6), .INST_MEMORY_DATA_BUS_WIDTH(32),
                  .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave),
        .cpu_hold(hold_b), .done(done_b), .error(err_b));

    logic        o_ready, o_we, o_hold, o_done, o_err;
    logic [15:0] o_addr;
    logic [31:0] o_wdata;

    always_comb begin
        if (sel_b) begin
            o_ready = if_b.byte_ready; o_we = if_b.mem_we;
            o_addr  = {10'd0, if_b.mem_addr}; o_wdata = if_b.mem_wdata;
            o_hold  = hold_b; o_done = done_b; o_err = err_b;
        end else begin
            o_ready = if_a.byte_ready; o_we = if_a.mem_we;
            o_addr  = if_a.mem_addr; o_wdata = if_a.mem_wdata;
            o_hold  = hold_a; o_done = done_a; o_err = err_a;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];

    // Record every write of the observed instance; byte_ready must be low in WRITE.
    always @(negedge clk) begin
        if (o_we) begin
            wq.push_back('{addr: o_addr, data: o_wdata});
            check1("ready low in WRITE", o_ready, 1'b0);
        end
    end

    logic [7:0] csum;

    task automatic do_reset(input logic use_b);
        sel_b = use_b; byte_valid = 1'b0; byte_in = 8'h00;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = use_b; rst_b = !use_b;
        wq.delete();
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget, output bit acc);
        bit rdy;
        acc = 1'b0;
        byte_in = b; byte_valid = 1'b1;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk); rdy = o_ready;
            @(posedge clk); #1;
            acc = rdy;
        end
        byte_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        bit acc;
        send_byte(b, 20, acc);
        if (!acc) begin
            n_checks++;
            $display("FAIL byte accept timeout: byte 0x%0h not accepted, expected acceptance", b);
        end
        csum = csum ^ b;
    endtask

    task automatic send_len(input logic [15:0] n);
        logic [15:0] v;
        v = n;
        put(v[7:0]); put(v[15:8]);
        csum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            put(v[8*i +: 8]);
        end
    endtask

    task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
        put(csum);
`endif
    endtask

    task automatic wait_end();
        int i;
        i = 0;
        while (!(o_done || o_err) && i < 20) begin @(posedge clk); #1; i++; end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        rdy, we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        hold, done, err;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mkv(input logic v, input logic [7:0] b, input logic rdy,
                                 input logic we, input logic [15:0] addr,
                                 input logic [31:0] wd, input logic hold,
                                 input logic dn, input logic er);
        vec_t r;
        r = '{v: v, b: b, rdy: rdy, we: we, addr: addr, wdata: wd, hold: hold, done: dn, err: er};
        return r;
    endfunction

    logic [31:0] words3[3];
    bit          acc;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        csum = 8'h00;

        // Reset state of dut_a.
        do_reset(1'b0);
        check1("reset ready", o_ready, 1'b1);
        check1("reset we", o_we, 1'b0);
        check("reset addr", 32'(o_addr), 32'h100);
        check("reset wdata", o_wdata, 32'h0);
        check1("reset hold", o_hold, 1'b1);
        check1("reset done", o_done, 1'b0);
        check1("reset error", o_err, 1'b0);

        // Empty image: done one cycle after the second length byte.
        send_len(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        check1("empty awaits trailer", o_ready, 1'b1);
        check1("empty not done yet", o_done, 1'b0);
        #4;
        put(8'h00);
`endif
        @(negedge clk);
        check1("empty done", o_done, 1'b1);
        check1("empty hold released", o_hold, 1'b0);
        check1("empty ready low", o_ready, 1'b0);
        check("empty no writes", 32'(wq.size()), 32'd0);

        // Three words with random valid gaps at BASE_ADDR=0x100.
        do_reset(1'b0);
        words3[0] = 32'hDEADBEEF; words3[1] = 32'h0BADF00D; words3[2] = 32'hCAFEBABE;
        send_len(16'd3);
        for (int i = 0; i < 3; i++) send_word(words3[i], 1'b1);
        send_trailer();
        wait_end();
        @(negedge clk);
        check("3w write count", 32'(wq.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            check($sformatf("3w addr %0d", i), 32'(wq[i].addr), 32'h100 + 32'(4 * i));
            check($sformatf("3w data %0d", i), wq[i].data, words3[i]);
        end
        check1("3w done", o_done, 1'b1);
        check1("3w hold", o_hold, 1'b0);

        // Single word, cycle-exact table on dut_b.
        do_reset(1'b1);
        vt.push_back(mkv(1, 8'h01, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'h00, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'h78, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'h56, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'h34, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'h12, 1, 0, 16'h0, 32'h0,        1, 0, 0));
        vt.push_back(mkv(1, 8'hEE, 0, 1, 16'h0, 32'h12345678, 1, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vt.push_back(mkv(1, 8'h08, 1, 0, 16'h0, 32'h0,        1, 0, 0));
`endif
        vt.push_back(mkv(1, 8'hEE, 0, 0, 16'h0, 32'h0,        0, 1, 0));
        vt.push_back(mkv(0, 8'h00, 0, 0, 16'h0, 32'h0,        0, 1, 0));
        foreach (vt[i]) begin
            byte_valid = vt[i].v; byte_in = vt[i].b;
            @(negedge clk);
            check1($sformatf("sw%0d ready", i), o_ready, vt[i].rdy);
            check1($sformatf("sw%0d we", i), o_we, vt[i].we);
            if (vt[i].we) begin
                check($sformatf("sw%0d addr", i), 32'(o_addr), 32'(vt[i].addr));
                check($sformatf("sw%0d wdata", i), o_wdata, vt[i].wdata);
            end
            check1($sformatf("sw%0d hold", i), o_hold, vt[i].hold);
            check1($sformatf("sw%0d done", i), o_done, vt[i].done);
            check1($sformatf("sw%0d error", i), o_err, vt[i].err);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check("sw write count", 32'(wq.size()), 32'd1);

        // Capacity overflow: AW=6 holds 16 words, N=17 aborts.
        do_reset(1'b1);
        send_len(16'd17);
        @(negedge clk);
        check1("ovf error", o_err, 1'b1);
        check1("ovf ready", o_ready, 1'b0);
        check1("ovf hold", o_hold, 1'b1);
        check1("ovf done", o_done, 1'b0);
        #4;
        send_byte(8'h55, 4, acc);
        check1("ovf byte refused", acc, 1'b0);
        check("ovf no writes", 32'(wq.size()), 32'd0);

        // Exactly full: N=16 fills 0x00..0x3C.
        do_reset(1'b1);
        send_len(16'd16);
        for (int i = 0; i < 16; i++) send_word(32'hA5000000 | 32'(i), 1'b0);
        send_trailer();
        wait_end();
        @(negedge clk);
        check1("full done", o_done, 1'b1);
        check("full write count", 32'(wq.size()), 32'd16);
        if (wq.size() == 16) begin
            check("full first addr", 32'(wq[0].addr), 32'h00);
            check("full last addr", 32'(wq[15].addr), 32'h3C);
            check("full last data", wq[15].data, 32'hA500000F);
        end

        // Reset mid-word with a byte offered during reset, then a fresh image.
        do_reset(1'b1);
        send_len(16'd2);
        put(8'hAA); put(8'hBB);
        byte_in = 8'hCC; byte_valid = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; byte_valid = 1'b0;
        check1("midrst ready", o_ready, 1'b1);
        check1("midrst we", o_we, 1'b0);
        check("midrst addr", 32'(o_addr), 32'h0);
        check("midrst wdata", o_wdata, 32'h0);
        check1("midrst hold", o_hold, 1'b1);
        check1("midrst done", o_done, 1'b0);
        send_len(16'd1);
        send_word(32'hDDCCBBAA, 1'b0);
        send_trailer();
        wait_end();
        @(negedge clk);
        check("midrst write count", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) begin
            check("midrst addr w0", 32'(wq[0].addr), 32'h0);
            check("midrst data w0", wq[0].data, 32'hDDCCBBAA);
        end
        check1("midrst done after image", o_done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong trailer: word stays written, loader aborts with the core held.
        do_reset(1'b1);
        send_len(16'd1);
        send_word(32'h12345678, 1'b0);
        @(negedge clk); #4;
        put(8'h01);
        @(negedge clk);
        check1("csum bad error", o_err, 1'b1);
        check1("csum bad done", o_done, 1'b0);
        check1("csum bad hold", o_hold, 1'b1);
        check("csum bad writes kept", 32'(wq.size()), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
